// File: rtl/pixel_stream_src.sv
// Frame-based test-pattern pixel source with a valid/ready output.
// Pixels are registered one beat ahead so the outputs never depend on ready.
module pixel_stream_src #(
    parameter int          IMG_W     = 32,
    parameter int          IMG_H     = 32,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk_in,
    input  logic        rstn,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  pat_sel,
    input  logic [7:0]  frames,
    output logic [7:0]  pixel_out,
    output logic        valid_out,
    input  logic        ready,
    output logic        sof,
    output logic        eol,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   row, row_nxt;
    logic [CW-1:0]   col, col_nxt;
    logic [7:0]      lfsr, lfsr_nxt;
    logic [1:0]      pat, pat_nxt;
    logic [7:0]      frames_r, frames_nxt;
    logic [15:0]     cnt_nxt, cnt_inc;
    logic            stop_pending, stop_nxt;
    logic            valid_nxt, sof_nxt, eol_nxt;
    logic [7:0]      pix_nxt;
    logic            load, transfer, last_col, last_row, run_done;

    function automatic logic [7:0] pattern(input logic [1:0] p, input logic [RW-1:0] r,
                                           input logic [CW-1:0] c, input logic [7:0] l);
        logic [7:0] r8, c8;
        r8 = 8'(r);
        c8 = 8'(c);
        case (p)
            2'b00:   return r8 * 8'(IMG_W) + c8;
            2'b01:   return c8;
            2'b10:   return (r8[3] ^ c8[3]) ? 8'hFF : 8'h00;
            default: return l;
        endcase
    endfunction

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            lfsr         <= LFSR_SEED;
            pat          <= 2'b00;
            frames_r     <= 8'd0;
            frame_cnt    <= 16'd0;
            stop_pending <= 1'b0;
            pixel_out    <= 8'd0;
            valid_out    <= 1'b0;
            sof          <= 1'b0;
            eol          <= 1'b0;
        end else begin
            state        <= state_nxt;
            row          <= row_nxt;
            col          <= col_nxt;
            lfsr         <= lfsr_nxt;
            pat          <= pat_nxt;
            frames_r     <= frames_nxt;
            frame_cnt    <= cnt_nxt;
            stop_pending <= stop_nxt;
            pixel_out    <= pix_nxt;
            valid_out    <= valid_nxt;
            sof          <= sof_nxt;
            eol          <= eol_nxt;
        end
    end

    // row/col/lfsr always describe the pixel currently presented; the next
    // pixel is computed from their advanced values and registered on transfer.
    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        col_nxt    = col;
        lfsr_nxt   = lfsr;
        pat_nxt    = pat;
        frames_nxt = frames_r;
        cnt_nxt    = frame_cnt;
        stop_nxt   = stop_pending;
        valid_nxt  = valid_out;
        pix_nxt    = pixel_out;
        sof_nxt    = sof;
        eol_nxt    = eol;
        load       = 1'b0;

        transfer = valid_out && ready;
        last_col = (col == CW'(IMG_W - 1));
        last_row = (row == RW'(IMG_H - 1));
        cnt_inc  = frame_cnt + 16'd1;
        run_done = stop_pending || stop || ((frames_r != 8'd0) && (cnt_inc == {8'd0, frames_r}));

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = RUN;
                    pat_nxt    = pat_sel;
                    frames_nxt = frames;
                    cnt_nxt    = 16'd0;
                    row_nxt    = '0;
                    col_nxt    = '0;
                    lfsr_nxt   = LFSR_SEED;
                    stop_nxt   = stop;
                    valid_nxt  = 1'b1;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    stop_nxt = 1'b1;
                end
                if (transfer) begin
                    if (last_col && last_row) begin
                        cnt_nxt  = (frame_cnt == 16'hFFFF) ? frame_cnt : cnt_inc;
                        row_nxt  = '0;
                        col_nxt  = '0;
                        lfsr_nxt = LFSR_SEED;
                        if (run_done) begin
                            state_nxt = IDLE;
                            stop_nxt  = 1'b0;
                            valid_nxt = 1'b0;
                            sof_nxt   = 1'b0;
                            eol_nxt   = 1'b0;
                        end else begin
                            pat_nxt = pat_sel;
                            load    = 1'b1;
                        end
                    end else begin
                        lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                        load     = 1'b1;
                        if (last_col) begin
                            col_nxt = '0;
                            row_nxt = row + RW'(1);
                        end else begin
                            col_nxt = col + CW'(1);
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            pix_nxt = pattern(pat_nxt, row_nxt, col_nxt, lfsr_nxt);
            sof_nxt = (row_nxt == '0) && (col_nxt == '0);
            eol_nxt = (col_nxt == CW'(IMG_W - 1));
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_pixel_stream_src.sv
// Self-checking bench for pixel_stream_src: randomized backpressure against a
// coordinate-based reference model of the four test patterns.
module tb_pixel_stream_src;

    localparam int W = 32;
    localparam int H = 32;
    localparam int N = W * H;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk_in = 1'b0;
    logic        rstn, start, stop, ready;
    logic [1:0]  pat_sel;
    logic [7:0]  frames;
    logic [7:0]  pixel_out;
    logic        valid_out, sof, eol, busy;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    pixel_stream_src #(.IMG_W(W), .IMG_H(H), .LFSR_SEED(SEED)) dut (
        .clk_in(clk_in), .rstn(rstn), .start(start), .stop(stop),
        .pat_sel(pat_sel), .frames(frames), .pixel_out(pixel_out),
        .valid_out(valid_out), .ready(ready), .sof(sof), .eol(eol),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] ref_pix(input int p, input int k, input logic [7:0] lf);
        int r, c;
        r = k / W;
        c = k % W;
        case (p)
            0:       return 8'((r * W + c) % 256);
            1:       return 8'(c % 256);
            2:       return ((((r / 8) + (c / 8)) % 2) == 1) ? 8'hFF : 8'h00;
            default: return lf;
        endcase
    endfunction

    function automatic logic [7:0] ref_lfsr_step(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

    // Waits for one transfer with the given ready probability, capturing the
    // beat and flagging any change of the presented beat while stalled.
    task automatic get_beat(input int pct, output logic [7:0] px, output logic s, output logic e,
                            output bit unstable, output bit timeout);
        bit have, r, vb;
        logic [7:0] hp;
        logic hs, he;
        have = 0; unstable = 0; timeout = 1;
        hp = 8'd0; hs = 1'b0; he = 1'b0;
        px = 8'd0; s = 1'b0; e = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (have && (valid_out !== 1'b1 || pixel_out !== hp || sof !== hs || eol !== he))
                unstable = 1;
            vb = (valid_out === 1'b1);
            r = ($urandom_range(99) < pct);
            ready = r;
            if (vb) begin
                have = 1; hp = pixel_out; hs = sof; he = eol;
            end
            @(posedge clk_in); #1;
            if (vb && r) begin
                px = hp; s = hs; e = he; timeout = 0;
                break;
            end
        end
        ready = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] p, input logic [7:0] f, input logic with_stop);
        pat_sel = p; frames = f; start = 1'b1; stop = with_stop;
        @(posedge clk_in); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (pixel_out !== 8'd0 || valid_out !== 1'b0 || sof !== 1'b0 || eol !== 1'b0 ||
            busy !== 1'b0 || frame_cnt !== 16'd0)
            $display("[TB] FAIL reset_state: px=%h v=%b sof=%b eol=%b busy=%b cnt=%0d, required all 0",
                     pixel_out, valid_out, sof, eol, busy, frame_cnt);
        rstn = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: v=%b busy=%b, required 0 0", valid_out, busy);
        end
    endtask

    task automatic test_incr;
        logic [7:0] px; logic s, e; bit uns, to;
        start_run(2'b00, 8'd1, 1'b0);
        checks++;
        if (valid_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL incr_first_latency: v=%b busy=%b, required 1 1", valid_out, busy);
        end
        for (int k = 0; k < N; k++) begin
            get_beat(100, px, s, e, uns, to);
            checks++;
            if (to || px !== ref_pix(0, k, 8'd0) || s !== (k == 0) || e !== ((k % W) == W - 1)) begin
                errors++;
                $display("[TB] FAIL incr_beat %0d: px=%h sof=%b eol=%b to=%b, required px=%h sof=%b eol=%b",
                         k, px, s, e, to, ref_pix(0, k, 8'd0), (k == 0), ((k % W) == W - 1));
                if (to) return;
            end
        end
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL incr_end: v=%b busy=%b cnt=%0d, required 0 0 1", valid_out, busy, frame_cnt);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] px; logic s, e; bit uns, to;
        start_run(2'b00, 8'd1, 1'b0);
        for (int k = 0; k < N; k++) begin
            get_beat(50, px, s, e, uns, to);
            checks++;
            if (to || uns || px !== ref_pix(0, k, 8'd0) || s !== (k == 0) || e !== ((k % W) == W - 1)) begin
                errors++;
                $display("[TB] FAIL bp_beat %0d: px=%h sof=%b eol=%b unstable=%b to=%b, required px=%h stable",
                         k, px, s, e, uns, to, ref_pix(0, k, 8'd0));
                if (to) return;
            end
        end
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL bp_end: v=%b busy=%b cnt=%0d, required 0 0 1", valid_out, busy, frame_cnt);
        end
    endtask

    task automatic test_lfsr;
        logic [7:0] px, lf; logic s, e; bit uns, to;
        logic [7:0] first3 [3];
        first3[0] = 8'hA5; first3[1] = 8'h4A; first3[2] = 8'h95;
        start_run(2'b11, 8'd2, 1'b0);
        for (int f = 0; f < 2; f++) begin
            lf = SEED;
            for (int k = 0; k < N; k++) begin
                get_beat(70, px, s, e, uns, to);
                checks++;
                if (to || uns || px !== lf || s !== (k == 0)) begin
                    errors++;
                    $display("[TB] FAIL lfsr_beat f%0d k%0d: px=%h sof=%b to=%b, required px=%h sof=%b",
                             f, k, px, s, to, lf, (k == 0));
                    if (to) return;
                end
                if (f == 0 && k < 3) begin
                    checks++;
                    if (px !== first3[k]) begin
                        errors++;
                        $display("[TB] FAIL lfsr_first %0d: px=%h, required %h", k, px, first3[k]);
                    end
                end
                lf = ref_lfsr_step(lf);
            end
            if (f == 0) begin
                checks++;
                if (frame_cnt !== 16'd1 || valid_out !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL lfsr_between: cnt=%0d v=%b busy=%b, required 1 1 1",
                             frame_cnt, valid_out, busy);
                end
            end
        end
        checks++;
        if (frame_cnt !== 16'd2 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lfsr_end: cnt=%0d busy=%b, required 2 0", frame_cnt, busy);
        end
    endtask

    task automatic test_checker;
        logic [7:0] px; logic s, e; bit uns, to;
        start_run(2'b10, 8'd1, 1'b0);
        for (int k = 0; k < N; k++) begin
            if (k == 100) pat_sel = 2'b01;
            get_beat(60, px, s, e, uns, to);
            checks++;
            if (to || px !== ref_pix(2, k, 8'd0) || e !== ((k % W) == W - 1)) begin
                errors++;
                $display("[TB] FAIL checker_beat %0d: px=%h eol=%b to=%b, required px=%h",
                         k, px, e, to, ref_pix(2, k, 8'd0));
                if (to) return;
            end
            if (k == 8 || k == 8 * W) begin
                checks++;
                if (px !== 8'hFF) begin
                    errors++;
                    $display("[TB] FAIL checker_corner %0d: px=%h, required ff", k, px);
                end
            end
        end
    endtask

    task automatic test_stop;
        logic [7:0] px; logic s, e; bit uns, to;
        start_run(2'b00, 8'd0, 1'b0);
        for (int k = 0; k < N; k++) begin
            stop  = (k == 500);
            start = (k == 600);
            get_beat(100, px, s, e, uns, to);
            stop = 1'b0; start = 1'b0;
            checks++;
            if (to || px !== ref_pix(0, k, 8'd0) || s !== (k == 0)) begin
                errors++;
                $display("[TB] FAIL stop_beat %0d: px=%h sof=%b to=%b, required px=%h",
                         k, px, s, to, ref_pix(0, k, 8'd0));
                if (to) return;
            end
            if (k == 700) begin
                checks++;
                if (frame_cnt !== 16'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL stop_restart_ignored: cnt=%0d busy=%b, required 0 1", frame_cnt, busy);
                end
            end
        end
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL stop_end: v=%b busy=%b cnt=%0d, required 0 0 1", valid_out, busy, frame_cnt);
        end
    endtask

    task automatic test_start_stop_same;
        logic [7:0] px; logic s, e; bit uns, to;
        start_run(2'b01, 8'd0, 1'b1);
        for (int k = 0; k < N; k++) begin
            get_beat(100, px, s, e, uns, to);
            checks++;
            if (to || px !== ref_pix(1, k, 8'd0)) begin
                errors++;
                $display("[TB] FAIL onestop_beat %0d: px=%h to=%b, required %h", k, px, to, ref_pix(1, k, 8'd0));
                if (to) return;
            end
        end
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL onestop_end: v=%b busy=%b cnt=%0d, required 0 0 1", valid_out, busy, frame_cnt);
        end
    endtask

    task automatic test_reset_midrun;
        logic [7:0] px; logic s, e; bit uns, to;
        start_run(2'b00, 8'd0, 1'b0);
        for (int k = 0; k < N + 300; k++) begin
            get_beat(100, px, s, e, uns, to);
            if (to) begin
                errors++; checks++;
                $display("[TB] FAIL rst_run_timeout: beat %0d, required a transfer", k);
                return;
            end
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL rst_precount: cnt=%0d, required 1", frame_cnt);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (pixel_out !== 8'd0 || valid_out !== 1'b0 || sof !== 1'b0 || eol !== 1'b0 ||
            busy !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rst_immediate: px=%h v=%b sof=%b eol=%b busy=%b cnt=%0d, required all 0",
                     pixel_out, valid_out, sof, eol, busy, frame_cnt);
        end
        @(posedge clk_in); #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_no_start: v=%b, required 0", valid_out);
        end
        start_run(2'b00, 8'd1, 1'b0);
        checks++;
        if (valid_out !== 1'b1 || pixel_out !== 8'h00 || sof !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_restart: v=%b px=%h sof=%b, required 1 00 1", valid_out, pixel_out, sof);
        end
        rstn = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0;
        pat_sel = 2'b00; frames = 8'd0;
        test_reset;
        test_incr;
        test_backpressure;
        test_lfsr;
        test_checker;
        test_stop;
        test_start_stop_same;
        test_reset_midrun;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
